// File: rtl/gfsbox_output_checker.sv
// Known-answer checker for AES-128 GFSbox (key 0): counts matching/mismatching ciphertexts, sticky done/pass verdict.
// Optional per-vector timeout enabled by defining GFSBOX_CHK_TIMEOUT_EN.
module gfsbox_output_checker #(
   parameter int NUM_VECTORS    = 7,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         ct_valid,
   input  logic [127:0] ciphertext,
   output logic         ct_ready,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [3:0]   pass_cnt,
   output logic [3:0]   fail_cnt,
   output logic [2:0]   first_fail_idx,
   output logic         timeout
);

   typedef enum logic [1:0] {IDLE, WAIT, CMP, DONE} state_t;

   localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);
   localparam logic [2:0] NO_FAIL  = 3'd7;

   function automatic logic [127:0] expected_ct(input logic [2:0] i);
      case (i)
         3'd0:    expected_ct = 128'h0336763e966d92595a567cc9ce537f5e;
         3'd1:    expected_ct = 128'ha9a1631bf4996954ebc093957b234589;
         3'd2:    expected_ct = 128'hff4f8391a6a40ca5b25d23bedd44a597;
         3'd3:    expected_ct = 128'hdc43be40be0e53712f7e2bf5ca707209;
         3'd4:    expected_ct = 128'h92beedab1895a94faa69b632e5cc47ce;
         3'd5:    expected_ct = 128'h459264f4798f6a78bacb89c15ed3d601;
         3'd6:    expected_ct = 128'h08a4e2efec8a8e3312ca7460b9040bbf;
         default: expected_ct = 128'h0;
      endcase
   endfunction

   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [127:0]  ct_q, ct_d;
   logic [3:0]    pass_cnt_q, pass_cnt_d;
   logic [3:0]    fail_cnt_q, fail_cnt_d;
   logic [2:0]    ffi_q, ffi_d;
   logic          ct_ready_q, busy_q, done_q, pass_q;
   logic          vec_done, vec_fail;

`ifdef GFSBOX_CHK_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmr_q, tmr_d;
   logic          timeout_q, timeout_d;
`endif

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      ct_d       = ct_q;
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      ffi_d      = ffi_q;
      vec_done   = 1'b0;
      vec_fail   = 1'b0;
`ifdef GFSBOX_CHK_TIMEOUT_EN
      timeout_d  = timeout_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = WAIT;
               idx_d      = 3'd0;
               pass_cnt_d = 4'd0;
               fail_cnt_d = 4'd0;
               ffi_d      = NO_FAIL;
`ifdef GFSBOX_CHK_TIMEOUT_EN
               timeout_d  = 1'b0;
`endif
            end
         end
         WAIT: begin
            if (ct_valid && ct_ready_q) begin
               ct_d    = ciphertext;
               state_d = CMP;
            end
`ifdef GFSBOX_CHK_TIMEOUT_EN
            // a handshake in the expiry cycle takes priority over the timeout
            else if (tmr_q == TMR_LAST) begin
               vec_done  = 1'b1;
               vec_fail  = 1'b1;
               timeout_d = 1'b1;
            end
`endif
         end
         CMP: begin
            vec_done = 1'b1;
            vec_fail = (ct_q != expected_ct(idx_q));
         end
         default: state_d = IDLE;
      endcase

      if (vec_done) begin
         if (vec_fail) begin
            fail_cnt_d = fail_cnt_q + 4'd1;
            if (ffi_q == NO_FAIL) ffi_d = idx_q;
         end else begin
            pass_cnt_d = pass_cnt_q + 4'd1;
         end
         idx_d   = idx_q + 3'd1;
         state_d = (idx_q == LAST_IDX) ? DONE : WAIT;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         idx_q      <= 3'd0;
         ct_q       <= 128'h0;
         pass_cnt_q <= 4'd0;
         fail_cnt_q <= 4'd0;
         ffi_q      <= NO_FAIL;
         ct_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         ct_q       <= ct_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         ffi_q      <= ffi_d;
         // status flags are registered from the next state so they track state_q exactly
         ct_ready_q <= (state_d == WAIT);
         busy_q     <= (state_d == WAIT) || (state_d == CMP);
         done_q     <= (state_d == DONE);
         pass_q     <= (state_d == DONE) && (fail_cnt_d == 4'd0);
      end
   end

`ifdef GFSBOX_CHK_TIMEOUT_EN
   always_comb begin
      tmr_d = tmr_q;
      if (vec_done || (state_d == WAIT && state_q != WAIT))
         tmr_d = '0;
      else if (state_q == WAIT)
         tmr_d = tmr_q + TW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmr_q     <= tmr_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign ct_ready       = ct_ready_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign pass_cnt       = pass_cnt_q;
   assign fail_cnt       = fail_cnt_q;
   assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_gfsbox_output_checker.sv
// Directed bench for gfsbox_output_checker: scoreboard of per-run verdicts plus reset/latency/ignore checks.
module tb_gfsbox_output_checker;

   logic         clk = 1'b0;
   logic         reset_n, start, ct_valid;
   logic [127:0] ciphertext;
   logic         ct_ready, busy, done, pass, timeout;
   logic [3:0]   pass_cnt, fail_cnt;
   logic [2:0]   first_fail_idx;

   logic         start1, ct_valid1;
   logic [127:0] ciphertext1;
   logic         ct_ready1, busy1, done1, pass1, timeout1;
   logic [3:0]   pass_cnt1, fail_cnt1;
   logic [2:0]   first_fail_idx1;

   gfsbox_output_checker #(.NUM_VECTORS(7), .TIMEOUT_CYCLES(16)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .ct_valid(ct_valid),
      .ciphertext(ciphertext), .ct_ready(ct_ready), .busy(busy), .done(done),
      .pass(pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .first_fail_idx(first_fail_idx), .timeout(timeout)
   );

   gfsbox_output_checker #(.NUM_VECTORS(1), .TIMEOUT_CYCLES(16)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .ct_valid(ct_valid1),
      .ciphertext(ciphertext1), .ct_ready(ct_ready1), .busy(busy1), .done(done1),
      .pass(pass1), .pass_cnt(pass_cnt1), .fail_cnt(fail_cnt1),
      .first_fail_idx(first_fail_idx1), .timeout(timeout1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int   pcnt;
      int   fcnt;
      int   ffi;
      logic pss;
      logic to;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] gold [7];
   int           compared = 0;
   int           mismatched = 0;
   int           rdy_cyc, done_cyc;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives vectors 0..n_stop-1; vector 'bad' gets bit 0 flipped, vector 'skip' is withheld.
   task automatic run(input int n_stop, input int bad, input int skip, input int start_at);
      int   k, it, wcnt, pc, fc, ffi;
      logic to;
      k = 0; it = 0; wcnt = 0; pc = 0; fc = 0; ffi = 7; to = 1'b0;
      rdy_cyc = -1;
      while (k < n_stop && it < 400) begin
         start      = (it == 0) || (it == start_at);
         ct_valid   = (k != skip);
         ciphertext = (k == bad) ? (gold[k] ^ 128'd1) : gold[k];
         if (ct_ready && rdy_cyc < 0) rdy_cyc = cyc;
         if (ct_ready) begin
            if (k == skip) begin
               wcnt++;
               if (wcnt == 16) begin
                  fc++; to = 1'b1;
                  if (ffi == 7) ffi = k;
                  k++;
               end
            end else begin
               if (ciphertext == gold[k]) pc++;
               else begin
                  fc++;
                  if (ffi == 7) ffi = k;
               end
               k++;
            end
         end
         @(negedge clk);
         it++;
      end
      start = 1'b0;
      ct_valid = 1'b0;
      if (it >= 400) check("run_budget_expired", 128'd0, 128'd1);
      if (n_stop == 7) sb.push_back('{pc, fc, ffi, (fc == 0), to});
   endtask

   task automatic wait_done_and_score(input string tag);
      exp_t e;
      int   n;
      n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      done_cyc = cyc;
      check({tag, "_done"}, done, 1'b1);
      if (sb.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 128'd0, 128'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_pass_cnt"}, pass_cnt, e.pcnt);
         check({tag, "_fail_cnt"}, fail_cnt, e.fcnt);
         check({tag, "_first_fail_idx"}, first_fail_idx, e.ffi);
         check({tag, "_pass"}, pass, e.pss);
         check({tag, "_timeout"}, timeout, e.to);
         check({tag, "_busy"}, busy, 1'b0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t e1;
      int   n;
      gold[0] = 128'h0336763e966d92595a567cc9ce537f5e;
      gold[1] = 128'ha9a1631bf4996954ebc093957b234589;
      gold[2] = 128'hff4f8391a6a40ca5b25d23bedd44a597;
      gold[3] = 128'hdc43be40be0e53712f7e2bf5ca707209;
      gold[4] = 128'h92beedab1895a94faa69b632e5cc47ce;
      gold[5] = 128'h459264f4798f6a78bacb89c15ed3d601;
      gold[6] = 128'h08a4e2efec8a8e3312ca7460b9040bbf;

      reset_n = 1'b0; start = 1'b0; ct_valid = 1'b0; ciphertext = '0;
      start1 = 1'b0; ct_valid1 = 1'b0; ciphertext1 = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // reset state
      check("rst_ct_ready", ct_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_pass", pass, 1'b0);
      check("rst_pass_cnt", pass_cnt, 4'd0);
      check("rst_fail_cnt", fail_cnt, 4'd0);
      check("rst_first_fail_idx", first_fail_idx, 3'd7);
      check("rst_timeout", timeout, 1'b0);

      // ct_valid in IDLE is ignored
      ct_valid = 1'b1; ciphertext = gold[0];
      repeat (2) @(negedge clk);
      ct_valid = 1'b0;
      @(negedge clk);
      check("idle_valid_busy", busy, 1'b0);
      check("idle_valid_pass_cnt", pass_cnt, 4'd0);
      check("idle_valid_ct_ready", ct_ready, 1'b0);

      // all vectors correct, back to back
      run(7, -1, -1, -1);
      wait_done_and_score("all_good");
      check("all_good_latency", done_cyc - rdy_cyc, 14);
      repeat (3) @(negedge clk);
      check("done_sticky", done, 1'b1);

      // vector 3 corrupted, start pulsed mid-run
      run(7, 3, -1, 6);
      wait_done_and_score("corrupt3");

      // abort at idx 4 with reset, then rerun cleanly
      run(4, -1, -1, -1);
      @(negedge clk);
      check("pre_reset_pass_cnt", pass_cnt, 4'd4);
      check("pre_reset_busy", busy, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_ct_ready", ct_ready, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_pass_cnt", pass_cnt, 4'd0);
      check("arst_first_fail_idx", first_fail_idx, 3'd7);
      check("arst_done", done, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run(7, -1, -1, -1);
      wait_done_and_score("after_reset");

`ifdef GFSBOX_CHK_TIMEOUT_EN
      // vector 2 withheld until the timeout fires
      run(7, -1, 2, -1);
      wait_done_and_score("timeout2");
`endif

      // single-vector configuration
      start1 = 1'b1; ct_valid1 = 1'b1; ciphertext1 = gold[0];
      sb.push_back('{1, 0, 7, 1'b1, 1'b0});
      @(negedge clk);
      start1 = 1'b0;
      check("nv1_ct_ready", ct_ready1, 1'b1);
      @(negedge clk);
      ct_valid1 = 1'b0;
      n = 0;
      while (!done1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      e1 = sb.pop_front();
      check("nv1_done", done1, 1'b1);
      check("nv1_pass_cnt", pass_cnt1, e1.pcnt);
      check("nv1_fail_cnt", fail_cnt1, e1.fcnt);
      check("nv1_first_fail_idx", first_fail_idx1, e1.ffi);
      check("nv1_pass", pass1, e1.pss);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
